// File: rtl/fpu_mul_arbiter_pkg.sv
// Shared FPU definitions: rounding modes, FP32 field widths and the
// sequencer state type for the multiplier arbiter.
package fpu_mul_arbiter_pkg;

   localparam logic [1:0] RM_POS_INF      = 2'b00;
   localparam logic [1:0] RM_NEG_INF      = 2'b01;
   localparam logic [1:0] RM_NEAREST_EVEN = 2'b10;
   localparam logic [1:0] RM_TIES_AWAY    = 2'b11;

   localparam int FP32_EXP_W  = 8;
   localparam int FP32_FRAC_W = 23;
   localparam int FP32_W      = 1 + FP32_EXP_W + FP32_FRAC_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } mul_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, and on
// contention the requester that did not win last time is chosen.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant    = 2'b00;
      grant[0] = req[0] & (~req[1] | last_grant);
      grant[1] = req[1] & (~req[0] | ~last_grant);
   end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Round-robin sequencer in front of the shared combinational FP32 multiplier:
// grants one requester, registers its operands, captures and returns the result.
//
// state | meaning
// IDLE  | waiting for a request; req_ready carries the grant
// EXEC  | operands on mul_*, result captured at the end of this cycle
// RESP  | tagged response held until rsp_ready
module fpu_mul_arbiter
   import fpu_mul_arbiter_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [FP32_W-1:0]    req_a0,
   input  logic [FP32_W-1:0]    req_b0,
   input  logic [FP32_W-1:0]    req_a1,
   input  logic [FP32_W-1:0]    req_b1,
   input  logic [1:0]           req_rm0,
   input  logic [1:0]           req_rm1,
   output logic [FP32_W-1:0]    mul_a,
   output logic [FP32_W-1:0]    mul_b,
   output logic [1:0]           mul_round_mode,
   input  logic [FP32_W-1:0]    mul_result,
   input  logic                 mul_overflow,
   input  logic                 mul_error,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [FP32_W-1:0]    rsp_result,
   output logic                 rsp_overflow,
   output logic                 rsp_error,
   output logic                 busy,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   mul_state_e            state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  cur_id_q, cur_id_d;
   logic [FP32_W-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [1:0]            mul_rm_q, mul_rm_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_id_q, rsp_id_d;
   logic [FP32_W-1:0]     rsp_result_q, rsp_result_d;
   logic                  rsp_overflow_q, rsp_overflow_d;
   logic                  rsp_error_q, rsp_error_d;
   logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic [1:0]            grant;

   rr_arbiter2 u_arb (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      cur_id_d       = cur_id_q;
      mul_a_d        = mul_a_q;
      mul_b_d        = mul_b_q;
      mul_rm_d       = mul_rm_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_id_d       = rsp_id_q;
      rsp_result_d   = rsp_result_q;
      rsp_overflow_d = rsp_overflow_q;
      rsp_error_d    = rsp_error_q;
      err_cnt_d      = err_cnt_q;
      req_ready      = 2'b00;

      case (state_q)
         ST_IDLE: begin
            req_ready = grant;
            if (grant != 2'b00) begin
               mul_a_d      = grant[1] ? req_a1  : req_a0;
               mul_b_d      = grant[1] ? req_b1  : req_b0;
               mul_rm_d     = grant[1] ? req_rm1 : req_rm0;
               cur_id_d     = grant[1];
               last_grant_d = grant[1];
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_valid_d    = 1'b1;
            rsp_id_d       = cur_id_q;
            rsp_result_d   = mul_result;
            rsp_overflow_d = mul_overflow;
            rsp_error_d    = mul_error;
            if (mul_error && (err_cnt_q != '1)) begin
               err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         last_grant_q   <= 1'b1;
         cur_id_q       <= 1'b0;
         mul_a_q        <= '0;
         mul_b_q        <= '0;
         mul_rm_q       <= RM_NEAREST_EVEN;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= 1'b0;
         rsp_result_q   <= '0;
         rsp_overflow_q <= 1'b0;
         rsp_error_q    <= 1'b0;
         err_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         cur_id_q       <= cur_id_d;
         mul_a_q        <= mul_a_d;
         mul_b_q        <= mul_b_d;
         mul_rm_q       <= mul_rm_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_id_q       <= rsp_id_d;
         rsp_result_q   <= rsp_result_d;
         rsp_overflow_q <= rsp_overflow_d;
         rsp_error_q    <= rsp_error_d;
         err_cnt_q      <= err_cnt_d;
      end
   end

   assign mul_a          = mul_a_q;
   assign mul_b          = mul_b_q;
   assign mul_round_mode = mul_rm_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_id         = rsp_id_q;
   assign rsp_result     = rsp_result_q;
   assign rsp_overflow   = rsp_overflow_q;
   assign rsp_error      = rsp_error_q;
   assign busy           = (state_q != ST_IDLE);
   assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Bench for fpu_mul_arbiter: a small FP32 multiplier stands in for the datapath,
// and a transaction-level model predicts grants, responses and the error count.
module tb_fpu_mul_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic [1:0]  req_rm0, req_rm1;
   logic [31:0] mul_a, mul_b;
   logic [1:0]  mul_round_mode;
   logic [31:0] mul_result;
   logic        mul_overflow, mul_error;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_overflow, rsp_error, busy;
   logic [7:0]  err_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fpu_mul_arbiter #(.ERR_CNT_W(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_a0         (req_a0),
      .req_b0         (req_b0),
      .req_a1         (req_a1),
      .req_b1         (req_b1),
      .req_rm0        (req_rm0),
      .req_rm1        (req_rm1),
      .mul_a          (mul_a),
      .mul_b          (mul_b),
      .mul_round_mode (mul_round_mode),
      .mul_result     (mul_result),
      .mul_overflow   (mul_overflow),
      .mul_error      (mul_error),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_id         (rsp_id),
      .rsp_result     (rsp_result),
      .rsp_overflow   (rsp_overflow),
      .rsp_error      (rsp_error),
      .busy           (busy),
      .err_cnt        (err_cnt)
   );

   // Simplified FP32 multiply: denormals flush to zero, fraction truncated.
   function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] rm);
      logic        s;
      logic [7:0]  ea, eb;
      logic [47:0] p;
      logic [22:0] mant;
      int          e;
      s  = a[31] ^ b[31];
      ea = a[30:23];
      eb = b[30:23];
      if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0))
         return {32'h7FC00000, 1'b0, 1'b1};
      if ((ea == 8'hFF && eb == 8'h00) || (ea == 8'h00 && eb == 8'hFF))
         return {32'h7FC00000, 1'b0, 1'b1};
      if (ea == 8'hFF || eb == 8'hFF)
         return {s, 8'hFF, 23'd0, 1'b0, 1'b0};
      if (ea == 8'h00 || eb == 8'h00)
         return {s, 31'd0, 1'b0, 1'b0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(ea) + int'(eb) - 127;
      if (p[47]) begin
         mant = p[46:24];
         e    = e + 1;
      end else begin
         mant = p[45:23];
      end
      if (e >= 255) begin
         if ((rm == 2'b00 && s) || (rm == 2'b01 && !s))
            return {s, 31'h7F7FFFFF, 1'b1, 1'b0};
         return {s, 8'hFF, 23'd0, 1'b1, 1'b0};
      end
      if (e <= 0)
         return {s, 31'd0, 1'b0, 1'b0};
      return {s, e[7:0], mant, 1'b0, 1'b0};
   endfunction

   always_comb {mul_result, mul_overflow, mul_error} = fmul(mul_a, mul_b, mul_round_mode);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one outstanding operation, 2-cycle result latency.
   bit          mon_en  = 1'b0;
   bit          m_out   = 1'b0;
   int          m_since = 0;
   bit          m_last  = 1'b1;
   int          m_cnt   = 0;
   bit          m_id    = 1'b0;
   logic [31:0] m_a     = '0;
   logic [31:0] m_b     = '0;
   logic [1:0]  m_rm    = 2'b10;
   logic [33:0] m_exp   = '0;

   always @(negedge clk) begin
      logic [1:0] g;
      bit         rv;
      if (mon_en) begin
         g = 2'b00;
         if (!m_out) begin
            if (req_valid == 2'b11) g = m_last ? 2'b01 : 2'b10;
            else                    g = req_valid;
         end
         rv = m_out && (m_since >= 2);
         chk("req_ready", req_ready, g);
         chk("busy", busy, m_out);
         chk("rsp_valid", rsp_valid, rv);
         chk("mul_a", mul_a, m_a);
         chk("mul_b", mul_b, m_b);
         chk("mul_rm", mul_round_mode, m_rm);
         chk("err_cnt", err_cnt, m_cnt);
         if (rv) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_result", rsp_result, m_exp[33:2]);
            chk("rsp_overflow", rsp_overflow, m_exp[1]);
            chk("rsp_error", rsp_error, m_exp[0]);
         end
         if (reset) begin
            m_out = 0; m_since = 0; m_last = 1; m_cnt = 0;
            m_a = '0; m_b = '0; m_rm = 2'b10;
         end else if (!m_out) begin
            if (g != 2'b00) begin
               m_id    = g[1];
               m_a     = g[1] ? req_a1  : req_a0;
               m_b     = g[1] ? req_b1  : req_b0;
               m_rm    = g[1] ? req_rm1 : req_rm0;
               m_exp   = fmul(m_a, m_b, m_rm);
               m_last  = g[1];
               m_out   = 1;
               m_since = 1;
            end
         end else if (m_since == 1) begin
            m_since = 2;
            if (m_exp[0] && m_cnt < 255) m_cnt++;
         end else if (rsp_ready) begin
            m_out = 0;
         end
      end
   end

   task automatic drive_req(input bit id, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] rm);
      if (id) begin req_a1 = a; req_b1 = b; req_rm1 = rm; end
      else    begin req_a0 = a; req_b0 = b; req_rm0 = rm; end
   endtask

   // Issue one operation and return at the negedge where the response is visible.
   task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, output logic [33:0] got);
      bit ok;
      int lat;
      @(posedge clk); #1;
      drive_req(id, a, b, rm);
      req_valid = id ? 2'b10 : 2'b01;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (req_ready[id]) ok = 1;
      end
      chk("accept_timeout", ok, 1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk("mul_a_after_accept", mul_a, a);
      chk("mul_b_after_accept", mul_b, b);
      ok  = 0;
      lat = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1; lat = i; end
      end
      chk("rsp_timeout", ok, 1);
      chk("rsp_latency", lat, 1);
      chk("rsp_id_op", rsp_id, id);
      got = {rsp_result, rsp_overflow, rsp_error};
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (!busy) ok = 1;
      end
      chk("drain_timeout", ok, 1);
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_op();
      int unsigned r;
      r = $urandom;
      case (r % 8)
         0: return {r[31], 31'd0};
         1: return {r[31], 8'hFF, 23'd0};
         2: return 32'h7FC00001;
         3: return {r[31], 8'd254, 23'($urandom)};
         default: return {r[31], 8'(100 + (r[15:8] % 56)), 23'($urandom)};
      endcase
   endfunction

   initial begin
      logic [33:0] got;
      logic [1:0]  order [4];
      int          n;
      bit          ok;

      reset = 1; req_valid = 0; rsp_ready = 1;
      req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0; req_rm0 = 0; req_rm1 = 0;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1;
      @(posedge clk); #1;
      reset = 0;

      // single request on requester 1: 1.5 * 2.0
      do_op(1'b1, 32'h3FC00000, 32'h40000000, 2'b10, got);
      chk("single_result", got[33:2], 32'h40400000);
      chk("single_flags", got[1:0], 2'b00);

      // contention: both valid continuously
      @(posedge clk); #1;
      drive_req(0, 32'h40000000, 32'h40400000, 2'b10);
      drive_req(1, 32'h3F800000, 32'hBF800000, 2'b10);
      req_valid = 2'b11;
      n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            order[n] = req_ready;
            n++;
         end
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk("contention_count", n, 4);
      chk("grant_0", order[0], 2'b01);
      chk("grant_1", order[1], 2'b10);
      chk("grant_2", order[2], 2'b01);
      chk("grant_3", order[3], 2'b10);
      drain();

      // back-pressure
      rsp_ready = 0;
      do_op(1'b0, 32'h40A00000, 32'h3F000000, 2'b10, got);
      @(posedge clk); #1;
      req_valid = 2'b11;
      repeat (5) @(posedge clk);
      #1;
      chk("bp_hold_result", {rsp_result, rsp_overflow, rsp_error}, got);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_ready_low", req_ready, 2'b00);
      rsp_ready = 1;
      @(negedge clk);
      chk("bp_no_grant_in_handshake", req_ready, 2'b00);
      @(negedge clk);
      chk("bp_grant_after_release", req_ready, 2'b10);
      @(posedge clk); #1;
      req_valid = 2'b00;
      drain();

      // error counting: inf * 0
      do_op(1'b0, 32'h7F800000, 32'h00000000, 2'b10, got);
      chk("inf_x_zero_error", got[0], 1);
      chk("err_cnt_first", err_cnt, 1);

      // overflow
      do_op(1'b1, 32'h7F000000, 32'h40000000, 2'b00, got);
      chk("ovf_result", got[33:2], 32'h7F800000);
      chk("ovf_flag", got[1], 1);

      // saturate the error counter
      for (int i = 0; i < 258; i++)
         do_op(i[0], 32'h00000000, 32'hFF800000, 2'b10, got);
      chk("err_cnt_saturated", err_cnt, 255);
      drain();

      // reset during EXEC; leave last winner = requester 0 beforehand
      do_op(1'b0, 32'h3F800000, 32'h3F800000, 2'b10, got);
      @(posedge clk); #1;
      drive_req(0, 32'h40000000, 32'h40000000, 2'b10);
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_rm", mul_round_mode, 2'b10);
      chk("rst_err_cnt", err_cnt, 0);
      req_valid = 2'b11;
      @(negedge clk);
      chk("rst_first_contention", req_ready, 2'b01);
      @(posedge clk); #1;
      req_valid = 2'b00;
      drain();

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         req_valid = 2'($urandom);
         req_a0 = rand_op(); req_b0 = rand_op();
         req_a1 = rand_op(); req_b1 = rand_op();
         req_rm0 = 2'($urandom); req_rm1 = 2'($urandom);
         rsp_ready = ($urandom % 4) != 0;
         reset = ($urandom % 100) == 0;
         @(posedge clk); #1;
      end
      reset = 0; req_valid = 0; rsp_ready = 1;
      drain();

      ok = 1;
      mon_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      if (ok) $finish;
   end

endmodule

// File: doc/fpu_mul_arbiter.md
# fpu_mul_arbiter

Two-requester round-robin arbiter and sequencer for the single shared combinational FP32 multiplier datapath. It accepts operand pairs over per-requester valid/ready handshakes and drives the winning operands and rounding mode into the multiplier from registers. It captures the result and exception flags and returns them on a single tagged response channel. It sits between the FPU issue logic and the multiplier, and keeps a saturating count of erroneous results.

## Interface
- Parameters:
- `ERR_CNT_W`, 8: width of the saturating error counter.
- Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 2: bit i = requester i has an operation.
- `req_ready` out 2: bit i = requester i is accepted this cycle.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 32: IEEE-754 single operands per requester.
- `req_rm0`, `req_rm1` in 2: rounding mode per requester (00 +inf, 01 -inf, 10 nearest-even, 11 ties-away).
- `mul_a`, `mul_b` out 32: registered operands to the multiplier.
- `mul_round_mode` out 2: registered rounding mode to the multiplier.
- `mul_result` in 32, `mul_overflow` in 1, `mul_error` in 1: multiplier outputs, purely combinational from `mul_*`.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out 1: requester index of the response.
- `rsp_result` out 32, `rsp_overflow` out 1, `rsp_error` out 1: captured results.
- `busy` out 1: state is not IDLE.
- `err_cnt` out ERR_CNT_W: count of responses with `rsp_error`=1, saturating at all-ones.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready` is nonzero only here. At most one bit is set; it marks the granted requester.
  - Only a requester with `req_valid` high can be granted.
  - If both are valid, grant goes to the requester not in `last_grant`.
  - On accept: latch the granter's A, B and rm into `mul_*`. Latch `cur_id` and set `last_grant`=`cur_id`. Go to EXEC.
- EXEC (exactly one cycle): capture `mul_result`/`mul_overflow`/`mul_error` into the `rsp_*` registers. Set `rsp_valid`=1 and go to RESP.
  - If that captured error is 1, increment `err_cnt` unless it is saturated.
- RESP: hold all `rsp_*` stable while `rsp_valid` is high.
  - On `rsp_valid&&rsp_ready`, clear `rsp_valid` and go to IDLE.
  - No new grant happens in the handshake cycle.
- `mul_*` hold their last values outside EXEC, so the multiplier sees no glitching from request-port changes.
- A requester dropping `req_valid` without a handshake is legal; it is simply not granted.
- Operands are never modified: NaN, infinity and zero handling is entirely the multiplier's.

## Timing
- Accept at edge N. Operands appear on `mul_*` after N. Result is captured at N+1. `rsp_valid` is high after N+1.
- Minimum issue interval is 3 cycles per operation with `rsp_ready` tied high.
- Reset values:
  - `req_ready`=0 (combinational, IDLE-only), `rsp_valid`=0, `rsp_id`=0.
  - `rsp_result`=0, `rsp_overflow`=0, `rsp_error`=0.
  - `mul_a`=`mul_b`=0, `mul_round_mode`=2'b10, `busy`=0, `err_cnt`=0.
  - `last_grant`=1, so requester 0 wins the first contention.
- Reset in EXEC or RESP aborts the operation with no response and no counter update. `reset` overrides all handshakes in the same cycle.
- Back-pressure: `rsp_ready` held low keeps RESP indefinitely, with outputs stable and `req_ready`=0.

## Structure
- Shared FPU package holds:
  - the rounding-mode constants (RM_POS_INF, RM_NEG_INF, RM_NEAREST_EVEN, RM_TIES_AWAY);
  - the FP32 field widths (8-bit exponent, 23-bit fraction);
  - the FSM state enum for this block.
- One natural sub-module: `rr_arbiter2`. It takes `req`[1:0] and `last_grant` and returns a one-hot `grant`. It is purely combinational.
- The rest is a single always-block FSM with registers.
- The multiplier is instantiated by the parent, not inside this block.

## Test plan
- Single request: A=0x3FC00000 (1.5), B=0x40000000 (2.0), rm=10 on requester 1.
  - Expect `mul_a`/`mul_b` driven 1 cycle later.
  - Expect `rsp_valid`, `rsp_id`=1 and `rsp_result`=0x40400000, 2 cycles after accept.
- Contention: both requesters valid continuously for 4 operations.
  - Expect grant order 0,1,0,1.
  - Expect `req_ready` never to have both bits set.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid`.
  - Expect `rsp_*` stable and `req_ready`=0.
  - On release, expect the handshake, then IDLE, with the next grant 1 cycle later.
- Error counting: send inf×0 (0x7F800000 × 0x00000000).
  - Expect `rsp_error`=1 and `err_cnt` +1.
  - Preload 255 via repeated errors; expect `err_cnt` to stay 255.
- Overflow: 0x7F000000 × 0x40000000 with rm=00.
  - Expect `rsp_result`=0x7F800000 and `rsp_overflow`=1.
- Reset mid-operation: assert `reset` during EXEC.
  - Expect no `rsp_valid`, all outputs at reset values the next cycle, and requester 0 winning the next contention.
